// File: rtl/imu_sample_sequencer.sv
// Periodic IMU burst reader: drives an I2C byte master through a register-pointer
// write plus a burst read, and double-buffers each completed sample.
module imu_sample_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter logic [7:0] START_REG      = 8'h3B,
  parameter int         NBYTES         = 14,
  parameter int         PERIOD_CYCLES  = 500000,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        sample_valid,
  output logic        busy,
  output logic [15:0] sample_count,
  output logic [7:0]  err_count,
  output logic [7:0]  overrun_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_W = 3'd1,
    REG    = 3'd2,
    ADDR_R = 3'd3,
    READ   = 3'd4,
    STOP   = 3'd5,
    ABORT  = 3'd6
  } state_t;

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST    = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(NBYTES - 1);

  localparam logic [2:0] OP_WRITE       = 3'd0;
  localparam logic [2:0] OP_START_WRITE = 3'd1;
  localparam logic [2:0] OP_READ_ACK    = 3'd2;
  localparam logic [2:0] OP_READ_NACK   = 3'd3;
  localparam logic [2:0] OP_STOP        = 3'd4;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q;
  logic [TW-1:0]   tcnt_q;
  logic            pending_q;
  logic            drop_q;
  logic [3:0]      byte_q;
  logic            rd_sel_q;
  logic [7:0]      bank_mem [0:31];

  logic tick, rsp_take, timeout, nack_err, done_ok;

  // Handshake: a command transfers on the cycle cmd_valid && cmd_ready; from then
  // until its rsp_valid (or a timeout) the command is pending and cmd_valid stays low.
  // A rsp_valid that arrives with nothing pending, or the first one after a timeout,
  // is discarded.
  always_comb begin
    tick     = (pcnt_q == P_LAST);
    rsp_take = rsp_valid && pending_q && !drop_q;
    timeout  = pending_q && !rsp_take && (tcnt_q == T_LAST);
    nack_err = rsp_take && rsp_nack &&
               ((state_q == ADDR_W) || (state_q == REG) || (state_q == ADDR_R));
  end

  always_comb begin
    state_d   = state_q;
    done_ok   = 1'b0;
    cmd_op    = OP_WRITE;
    cmd_data  = '0;
    case (state_q)
      IDLE: if (tick && enable) state_d = ADDR_W;
      ADDR_W: begin
        cmd_op   = OP_START_WRITE;
        cmd_data = {DEV_ADDR, 1'b0};
        if (rsp_take) state_d = rsp_nack ? ABORT : REG;
      end
      REG: begin
        cmd_op   = OP_WRITE;
        cmd_data = START_REG;
        if (rsp_take) state_d = rsp_nack ? ABORT : ADDR_R;
      end
      ADDR_R: begin
        cmd_op   = OP_START_WRITE;
        cmd_data = {DEV_ADDR, 1'b1};
        if (rsp_take) state_d = rsp_nack ? ABORT : READ;
      end
      READ: begin
        cmd_op = (byte_q == LAST_BYTE) ? OP_READ_NACK : OP_READ_ACK;
        if (rsp_take && (byte_q == LAST_BYTE)) state_d = STOP;
      end
      STOP: begin
        cmd_op = OP_STOP;
        if (rsp_take) begin
          state_d = IDLE;
          done_ok = 1'b1;
        end
      end
      ABORT: begin
        cmd_op = OP_STOP;
        if (rsp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A lost response inside the closing STOP leaves nothing further to clean up.
    if (timeout) state_d = ((state_q == STOP) || (state_q == ABORT)) ? IDLE : ABORT;
    cmd_valid = (state_q != IDLE) && !pending_q;
    if (!cmd_valid) begin
      cmd_op   = OP_WRITE;
      cmd_data = '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      pending_q     <= 1'b0;
      drop_q        <= 1'b0;
      byte_q        <= '0;
      rd_sel_q      <= 1'b0;
      sample_valid  <= 1'b0;
      sample_count  <= '0;
      err_count     <= '0;
      overrun_count <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= tick ? '0 : pcnt_q + 1'b1;
      sample_valid <= done_ok;
      if (done_ok) begin
        rd_sel_q     <= ~rd_sel_q;
        sample_count <= sample_count + 16'd1;
      end
      if (tick && enable && (state_q != IDLE) && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;
      if ((nack_err || timeout) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      if (cmd_valid && cmd_ready) begin
        pending_q <= 1'b1;
        tcnt_q    <= '0;
      end else if (rsp_take || timeout) begin
        pending_q <= 1'b0;
      end else if (pending_q) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (timeout) drop_q <= 1'b1;
      else if (rsp_valid && drop_q) drop_q <= 1'b0;
      if ((state_q != READ) && (state_d == READ)) byte_q <= '0;
      else if ((state_q == READ) && rsp_take) byte_q <= byte_q + 4'd1;
    end
  end

  // Bank storage carries no reset so a stale sample survives a reset.
  always_ff @(posedge clk_clk) begin
    if ((state_q == READ) && rsp_take) bank_mem[{~rd_sel_q, byte_q}] <= rsp_data;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) rd_data <= '0;
    else                rd_data <= bank_mem[{rd_sel_q, rd_addr}];
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_imu_sample_sequencer.sv
// Directed bench for imu_sample_sequencer: a responder models the I2C byte master,
// a monitor checks every accepted command and buffer read against expected queues.
module tb_imu_sample_sequencer;

  localparam int PERIOD = 100;
  localparam int TMO    = 20;
  localparam int NB     = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        rsp_nack = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic [7:0]  rd_data;
  logic        sample_valid, busy;
  logic [15:0] sample_count;
  logic [7:0]  err_count, overrun_count;
  logic [2:0]  state_dbg;

  imu_sample_sequencer #(
    .DEV_ADDR(7'h68), .START_REG(8'h3B), .NBYTES(NB),
    .PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .rd_addr(rd_addr), .rd_data(rd_data), .sample_valid(sample_valid), .busy(busy),
    .sample_count(sample_count), .err_count(err_count), .overrun_count(overrun_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sv_seen  = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];

  int         ready_mode = 0;
  logic       ready_hold = 1'b0;
  logic       nack_once  = 1'b0;
  logic       drop_en    = 1'b0;
  int         drop_k     = 0;
  logic [7:0] rd_base    = 8'h00;
  logic       rd_strobe  = 1'b0;
  logic       rd_live    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // cmd_ready driver
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_hold || ready_mode == 1) cmd_ready = 1'b0;
      else if (ready_mode == 2)          cmd_ready = 1'($urandom_range(0, 1));
      else                               cmd_ready = 1'b1;
    end
  end

  // responder: one response per accepted command, one cycle after acceptance
  initial begin
    int rk;
    logic [2:0] op;
    logic [7:0] d;
    rk = 0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        op = cmd_op;
        d  = cmd_data;
        @(posedge clk); #1;
        if (op == 3'd1 && d == 8'hD1) rk = 0;
        if ((op == 3'd2 || op == 3'd3) && drop_en && rk == drop_k) begin
          drop_en    = 1'b0;
          ready_hold = 1'b1;
          repeat (24) @(posedge clk);
          #1;
          rsp_valid = 1'b1;
          rsp_data  = 8'hEE;
          @(posedge clk); #1;
          rsp_valid  = 1'b0;
          ready_hold = 1'b0;
        end else begin
          rsp_valid = 1'b1;
          rsp_nack  = (op == 3'd1 && d == 8'hD0 && nack_once);
          if (rsp_nack) nack_once = 1'b0;
          rsp_data  = (op == 3'd2 || op == 3'd3) ? rd_base + 8'(rk) : 8'h00;
          if (op == 3'd2 || op == 3'd3) rk++;
          @(posedge clk); #1;
          rsp_valid = 1'b0;
          rsp_nack  = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) rd_live <= rd_strobe;

  // scoreboard monitor
  initial begin
    logic stall_q;
    logic [2:0] p_op;
    logic [7:0] p_data;
    logic [10:0] e;
    logic [7:0] er;
    stall_q = 1'b0;
    p_op = '0;
    p_data = '0;
    forever begin
      @(negedge clk);
      if (sample_valid) sv_seen++;
      if (stall_q && rst_n) check("cmd_stable", {cmd_valid, cmd_op, cmd_data}, {1'b1, p_op, p_data});
      stall_q = rst_n && cmd_valid && !cmd_ready;
      p_op    = cmd_op;
      p_data  = cmd_data;
      if (rst_n && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cmd_unexpected: got op %0d data 0x%0h expected none", cmd_op, cmd_data);
        end else begin
          e = exp_q.pop_front();
          check("cmd", {cmd_op, cmd_data}, e);
        end
      end
      if (rd_live) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", rd_data);
        end else begin
          er = exp_rd_q.pop_front();
          check("rd_data", rd_data, er);
        end
      end
    end
  end

  // driver tasks
  task automatic push_full(input logic [7:0] base);
    rd_base = base;
    exp_q.push_back({3'd1, 8'hD0});
    exp_q.push_back({3'd0, 8'h3B});
    exp_q.push_back({3'd1, 8'hD1});
    for (int k = 0; k < NB - 1; k++) exp_q.push_back({3'd2, 8'h00});
    exp_q.push_back({3'd3, 8'h00});
    exp_q.push_back({3'd4, 8'h00});
  endtask

  task automatic read_all(input logic [7:0] base);
    for (int k = 0; k < NB; k++) begin
      @(posedge clk); #1;
      rd_addr   = 4'(k);
      rd_strobe = 1'b1;
      exp_rd_q.push_back(base + 8'(k));
    end
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    repeat (3) @(posedge clk);
    check("rd_q_drained", exp_rd_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_op", cmd_op, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_sample_count", sample_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_overrun_count", overrun_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_state", state_dbg, 0);
  endtask

  task automatic measure_start(input int exp_cycles);
    int cnt;
    cnt = 0;
    enable = 1'b1;
    while (cnt < 400) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (busy) break;
    end
    check("start_latency", cnt, exp_cycles);
  endtask

  task automatic wait_busy(input int budget);
    int cnt;
    cnt = 0;
    enable = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
    end while (!busy && cnt < budget);
    check("wait_busy", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < budget);
    check("wait_idle", busy, 0);
    check("cmd_q_drained", exp_q.size(), 0);
  endtask

  task automatic check_counts(input int sc, input int ec, input int oc, input int sv);
    check("sample_count", sample_count, sc);
    check("err_count", err_count, ec);
    check("overrun_count", overrun_count, oc);
    check("sample_valid_pulses", sv_seen, sv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // normal read, with start latency from reset
    push_full(8'h10);
    measure_start(PERIOD);
    enable = 1'b0;
    wait_idle(300);
    check_counts(1, 0, 0, 1);
    read_all(8'h10);

    // NACK on the address phase
    nack_once = 1'b1;
    exp_q.push_back({3'd1, 8'hD0});
    exp_q.push_back({3'd4, 8'h00});
    wait_busy(250);
    enable = 1'b0;
    wait_idle(300);
    check_counts(1, 1, 0, 1);
    read_all(8'h10);

    // overrun while the byte master stalls
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    push_full(8'h20);
    wait_busy(250);
    repeat (250) @(posedge clk);
    #1;
    enable = 1'b0;
    ready_mode = 0;
    wait_idle(300);
    check_counts(2, 1, 2, 2);
    read_all(8'h20);

    // timeout after READ_ACK byte 3, late stray response
    drop_en = 1'b1;
    drop_k  = 3;
    rd_base = 8'h30;
    exp_q.push_back({3'd1, 8'hD0});
    exp_q.push_back({3'd0, 8'h3B});
    exp_q.push_back({3'd1, 8'hD1});
    for (int k = 0; k < 4; k++) exp_q.push_back({3'd2, 8'h00});
    exp_q.push_back({3'd4, 8'h00});
    wait_busy(250);
    enable = 1'b0;
    wait_idle(300);
    check_counts(2, 2, 2, 2);
    read_all(8'h20);

    // reset in the middle of READ
    rd_base = 8'h40;
    exp_q.push_back({3'd1, 8'hD0});
    exp_q.push_back({3'd0, 8'h3B});
    exp_q.push_back({3'd1, 8'hD1});
    for (int k = 0; k < 5; k++) exp_q.push_back({3'd2, 8'h00});
    wait_busy(250);
    enable = 1'b0;
    begin
      int cnt;
      cnt = 0;
      do begin
        @(posedge clk);
        cnt++;
      end while (exp_q.size() != 0 && cnt < 200);
      check("pre_reset_cmds", exp_q.size(), 0);
    end
    #1;
    do_reset(1);
    push_full(8'h50);
    measure_start(PERIOD);
    enable = 1'b0;
    wait_idle(300);
    check_counts(1, 0, 0, 3);
    read_all(8'h50);

    // random backpressure
    ready_mode = 2;
    push_full(8'h60);
    wait_busy(250);
    enable = 1'b0;
    wait_idle(800);
    ready_mode = 0;
    check_counts(2, 0, 0, 4);
    read_all(8'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imu_sample_sequencer.md
IMU_SAMPLE_SEQUENCER -- requirements
Module: imu_sample_sequencer

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68: 7-bit I2C address of the IMU.
REQ-002 Parameter START_REG, default 8'h3B: first IMU register of the burst read.
REQ-003 Parameter NBYTES, default 14, legal range 2..16: number of bytes read per sample.
REQ-004 Parameter PERIOD_CYCLES, default 500000: clock cycles between sample ticks (100 Hz at 50 MHz).
REQ-005 Parameter TIMEOUT_CYCLES, default 65535: maximum wait for any single I2C response.
REQ-006 clk_clk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-007 reset_reset_n  in  1  synchronous, active-low reset.
REQ-008 enable  in  1  1 = periodic sampling allowed.
REQ-009 cmd_valid  out  1  command to the I2C byte master is valid.
REQ-010 cmd_ready  in  1  the I2C byte master accepts the command.
REQ-011 cmd_op  out  3  0 WRITE, 1 START_WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP; codes 5..7 are never driven.
REQ-012 cmd_data  out  8  byte to send for WRITE and START_WRITE; 0 for all other ops.
REQ-013 rsp_valid  in  1  one-cycle pulse; exactly one per accepted command.
REQ-014 rsp_data  in  8  received byte; meaningful for READ_ACK and READ_NACK only.
REQ-015 rsp_nack  in  1  slave NACK; meaningful for WRITE and START_WRITE only.
REQ-016 rd_addr  in  4  index into the sample buffer.
REQ-017 rd_data  out  8  sample buffer byte at rd_addr, registered.
REQ-018 sample_valid  out  1  one-cycle pulse when a new sample becomes readable.
REQ-019 busy  out  1  1 whenever the state is not IDLE.
REQ-020 sample_count  out  16  count of successful samples, wrapping.
REQ-021 err_count  out  8  count of NACKs plus timeouts, saturating at 255.
REQ-022 overrun_count  out  8  count of dropped ticks, saturating at 255.

Function
REQ-023 The period counter SHALL run freely from 0 to PERIOD_CYCLES-1 and wrap; tick is asserted in the cycle where the count equals PERIOD_CYCLES-1.
REQ-024 Tick with enable=1 in IDLE SHALL start a transaction in the next cycle.
REQ-025 Tick with enable=1 while busy=1 SHALL be dropped, not queued, and SHALL increment overrun_count.
REQ-026 A tick with enable=0 SHALL be ignored.
REQ-027 States: IDLE, ADDR_W, REG, ADDR_R, READ, STOP, ABORT.
REQ-028 The per-state command sequence SHALL be as follows, each state issuing its command(s) and then waiting for the response:
- ADDR_W: START_WRITE with data {DEV_ADDR,0}.
- REG: WRITE with data START_REG.
- ADDR_R: START_WRITE with data {DEV_ADDR,1}.
- READ: READ_ACK for bytes 0..NBYTES-2, then READ_NACK for byte NBYTES-1.
- STOP: STOP.
REQ-029 cmd_valid SHALL remain high, with cmd_op and cmd_data stable, until the cycle where cmd_valid and cmd_ready are both 1.
REQ-030 No new command SHALL be issued until the rsp_valid for the previous command has been received.
REQ-031 At most one command SHALL be outstanding at any time.
REQ-032 A rsp_valid received while no command is outstanding SHALL be ignored.
REQ-033 Read byte k SHALL be written to the write bank at index k, with k counting 0..NBYTES-1.
REQ-034 The sample buffer SHALL consist of two 16x8 banks; rd_data SHALL always come from the read bank, with 1-cycle latency from rd_addr.
REQ-035 On rsp_valid for the STOP command of an error-free transaction, the following SHALL happen in the same cycle:
- read and write banks swap;
- sample_valid pulses;
- sample_count increments;
- the state returns to IDLE.
REQ-036 rsp_nack=1 on any WRITE or START_WRITE response SHALL increment err_count and move the state to ABORT.
REQ-037 In ABORT the block SHALL issue STOP, return to IDLE on its response, perform no bank swap, and not pulse sample_valid.
REQ-038 The timeout counter SHALL reset on every command acceptance.
REQ-039 If a response is outstanding for TIMEOUT_CYCLES cycles, err_count SHALL increment and the state SHALL move to ABORT; a timeout while already in STOP or ABORT SHALL go directly to IDLE.
REQ-040 A timeout SHALL deassert cmd_valid and abandon any outstanding response; the first rsp_valid after the timeout is not consumed by the new state.
REQ-041 Deasserting enable mid-transaction SHALL NOT abort it; the transaction SHALL complete normally.
REQ-042 A stale bank SHALL remain readable, unchanged, until the next successful swap.

Reset
REQ-043 While reset_reset_n=0 at a rising edge, the block SHALL apply:
- state=IDLE;
- period counter=0, timeout counter=0;
- cmd_valid=0, cmd_op=0, cmd_data=0;
- sample_valid=0, busy=0;
- all three counters=0;
- read bank select=0;
- rd_data=0.
REQ-044 Bank contents are not reset; a reset mid-transaction SHALL discard the transaction without issuing STOP.

Verification
REQ-045 Normal read: PERIOD_CYCLES=100; the responder ACKs all writes and returns bytes 0x10..0x1D -> command sequence START_WRITE D0, WRITE 3B, START_WRITE D1, 13x READ_ACK, READ_NACK, STOP; sample_valid pulses once; rd_addr 0..13 reads 0x10..0x1D; sample_count=1.
REQ-046 NACK: the ADDR_W response has rsp_nack=1 -> the next command is STOP; err_count=1; no sample_valid; the buffer still holds the previous sample.
REQ-047 Overrun: cmd_ready is held low for 250 cycles with PERIOD_CYCLES=100 -> overrun_count=2 and the transaction then completes.
REQ-048 Timeout: TIMEOUT_CYCLES=20 and no rsp_valid after READ_ACK byte 3 -> err_count=1 after 20 cycles, STOP is issued, the state returns to IDLE, sample_count is unchanged.
REQ-049 Reset mid-READ: reset_reset_n=0 for 1 cycle -> all outputs take their reset values in the next cycle; no STOP is issued; a fresh transaction starts on the first tick after PERIOD_CYCLES.
REQ-050 Backpressure: cmd_ready is randomly toggled -> cmd_op and cmd_data stay stable while cmd_valid=1 and not ready; the byte order in the buffer is preserved.
